// File: rtl/mem_stage_access.sv
// EX/MEM consumer: runs load/store handshakes against a multi-cycle data RAM,
// stalls upstream while an access is outstanding and drives the MEM/WB register.
module mem_stage_access #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wmem_i,
  input  logic              rmem_i,
  input  logic              wreg_i,
  input  logic              wpc_i,
  input  logic [1:0]        jmp_i,
  input  logic [2:0]        alu_ins_i,
  input  logic [DATA_W-1:0] addr_val_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [3:0]        dest_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_wreg,
  output logic              wb_wpc,
  output logic [1:0]        wb_jmp,
  output logic [2:0]        wb_alu_ins,
  output logic [3:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              store;
    logic              wreg;
    logic              wpc;
    logic [1:0]        jmp;
    logic [2:0]        alu_ins;
    logic [3:0]        dest;
    logic [DATA_W-1:0] addr;
  } hold_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  hold_t         hold;
  logic [CW-1:0] cnt;
  logic          is_mem, to_hit;

  assign is_mem = wmem_i | rmem_i;
  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // Stall is gated by rst so every output reads 0 while reset is held.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = is_mem & ~rst;
        if (is_mem) state_nxt = ACCESS;
      end
      ACCESS: begin
        stall = ~rst;
        if (mem_ack || to_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold       <= '0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_wreg    <= 1'b0;
      wb_wpc     <= 1'b0;
      wb_jmp     <= '0;
      wb_alu_ins <= '0;
      wb_dest    <= '0;
      wb_data    <= '0;
      mem_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            hold       <= '{store: wmem_i, wreg: wreg_i, wpc: wpc_i, jmp: jmp_i,
                            alu_ins: alu_ins_i, dest: dest_i, addr: addr_val_i};
            mem_req    <= 1'b1;
            mem_we     <= wmem_i;
            mem_addr   <= addr_val_i;
            mem_wdata  <= st_data_i;
            cnt        <= '0;
            wb_valid   <= 1'b0;
          end else begin
            wb_data    <= addr_val_i;
            wb_wreg    <= wreg_i;
            wb_wpc     <= wpc_i;
            wb_jmp     <= jmp_i;
            wb_alu_ins <= alu_ins_i;
            wb_dest    <= dest_i;
            wb_valid   <= wreg_i | wpc_i | (jmp_i != 2'b00);
          end
        end
        ACCESS: begin
          wb_alu_ins <= hold.alu_ins;
          wb_dest    <= hold.dest;
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wb_data  <= hold.store ? hold.addr : mem_rdata;
            wb_wreg  <= hold.store ? 1'b0 : hold.wreg;
            wb_wpc   <= hold.wpc;
            wb_jmp   <= hold.jmp;
            wb_valid <= 1'b1;
          end else if (to_hit) begin
            // Aborted access completes as a harmless no-op instruction.
            mem_req  <= 1'b0;
            mem_err  <= 1'b1;
            wb_data  <= '0;
            wb_wreg  <= 1'b0;
            wb_wpc   <= 1'b0;
            wb_jmp   <= '0;
            wb_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    wb_valid <= 1'b0;
        default: wb_valid <= 1'b0;
      endcase
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: pass-through, loads, stores, timeout,
// back-to-back ops and reset mid-access, all with hand-computed expectations.
module tb_mem_stage_access;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              wmem_i, rmem_i, wreg_i, wpc_i;
  logic [1:0]        jmp_i;
  logic [2:0]        alu_ins_i;
  logic [DATA_W-1:0] addr_val_i, st_data_i, mem_rdata;
  logic [3:0]        dest_i;
  logic              mem_req, mem_we, mem_ack, stall;
  logic [DATA_W-1:0] mem_addr, mem_wdata, wb_data;
  logic              wb_valid, wb_wreg, wb_wpc, mem_err;
  logic [1:0]        wb_jmp;
  logic [2:0]        wb_alu_ins;
  logic [3:0]        wb_dest;

  int n_chk = 0;
  int n_fail = 0;

  mem_stage_access #(.DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .wmem_i(wmem_i), .rmem_i(rmem_i), .wreg_i(wreg_i), .wpc_i(wpc_i),
    .jmp_i(jmp_i), .alu_ins_i(alu_ins_i), .addr_val_i(addr_val_i),
    .st_data_i(st_data_i), .dest_i(dest_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wpc(wb_wpc),
    .wb_jmp(wb_jmp), .wb_alu_ins(wb_alu_ins), .wb_dest(wb_dest),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    wmem_i = 0; rmem_i = 0; wreg_i = 0; wpc_i = 0; jmp_i = 0; alu_ins_i = 0;
    addr_val_i = 0; st_data_i = 0; dest_i = 0;
  endtask

  task automatic load_op(input logic [31:0] a, input logic [3:0] d);
    clr_in();
    rmem_i = 1; wreg_i = 1; addr_val_i = a; dest_i = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; mem_ack = 0; mem_rdata = 0;
    clr_in();
    rmem_i = 1;
    #12;
    // reset state, with a memory op presented
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_valid", wb_valid, 0);
    check("rst_err", mem_err, 0);
    clr_in();
    #1 rst = 0;
    tick();

    // ALU pass-through
    wreg_i = 1; dest_i = 4'h5; addr_val_i = 32'h1234; alu_ins_i = 3'd6;
    #1 check("alu_stall_idle", stall, 0);
    tick();
    check("alu_valid", wb_valid, 1);
    check("alu_wreg", wb_wreg, 1);
    check("alu_dest", wb_dest, 5);
    check("alu_data", wb_data, 32'h1234);
    check("alu_ins", wb_alu_ins, 6);
    check("alu_stall", stall, 0);
    clr_in();
    tick();
    check("bubble_valid", wb_valid, 0);

    // load, ack on second ACCESS cycle
    load_op(32'h40, 4'd3);
    #1 check("ld_stall0", stall, 1);
    tick();
    check("ld_req1", mem_req, 1);
    check("ld_we1", mem_we, 0);
    check("ld_addr1", mem_addr, 32'h40);
    check("ld_stall1", stall, 1);
    check("ld_valid_acc", wb_valid, 0);
    tick();
    check("ld_req2", mem_req, 1);
    check("ld_addr2", mem_addr, 32'h40);
    check("ld_stall2", stall, 1);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 0; mem_rdata = 0;
    check("ld_req_done", mem_req, 0);
    check("ld_stall_done", stall, 0);
    check("ld_valid", wb_valid, 1);
    check("ld_data", wb_data, 32'hDEADBEEF);
    check("ld_wreg", wb_wreg, 1);
    check("ld_dest", wb_dest, 3);
    tick();  // inputs still hold the load during DONE: must not re-issue
    check("ld_noreissue", mem_req, 0);
    check("ld_valid_off", wb_valid, 0);
    check("ld_data_hold", wb_data, 32'hDEADBEEF);
    clr_in();
    tick();

    // store with both flags set, immediate ack
    clr_in();
    wmem_i = 1; rmem_i = 1; wreg_i = 1; st_data_i = 32'hA5A5; addr_val_i = 32'h80;
    #1 check("st_stall0", stall, 1);
    tick();
    check("st_req", mem_req, 1);
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 32'hA5A5);
    check("st_addr", mem_addr, 32'h80);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("st_valid", wb_valid, 1);
    check("st_wreg", wb_wreg, 0);
    check("st_data", wb_data, 32'h80);
    clr_in();
    tick();

    // timeout: TIMEOUT=4, never ack
    load_op(32'h100, 4'd7); wpc_i = 1; jmp_i = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_req%0d", i), mem_req, 1);
      check($sformatf("to_err%0d", i), mem_err, 0);
    end
    tick();
    check("to_req_off", mem_req, 0);
    check("to_err", mem_err, 1);
    check("to_valid", wb_valid, 1);
    check("to_wreg", wb_wreg, 0);
    check("to_wpc", wb_wpc, 0);
    check("to_jmp", wb_jmp, 0);
    check("to_data", wb_data, 0);
    clr_in();
    tick();
    load_op(32'h44, 4'd1);
    tick();
    check("post_to_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h1111;
    tick();
    mem_ack = 0;
    check("post_to_data", wb_data, 32'h1111);
    check("post_to_err", mem_err, 1);
    clr_in();
    tick();

    // back-to-back load then store
    load_op(32'h8, 4'd2);
    tick();
    check("b2b_ld_addr", mem_addr, 32'h8);
    mem_ack = 1; mem_rdata = 32'hCAFE;
    tick();
    mem_ack = 0;
    check("b2b_ld_data", wb_data, 32'hCAFE);
    check("b2b_ld_dest", wb_dest, 2);
    clr_in();
    wmem_i = 1; addr_val_i = 32'hC; st_data_i = 32'h55;
    tick();
    check("b2b_gap_req", mem_req, 0);
    check("b2b_idle_stall", stall, 1);
    tick();
    check("b2b_st_req", mem_req, 1);
    check("b2b_st_we", mem_we, 1);
    check("b2b_st_addr", mem_addr, 32'hC);
    check("b2b_st_wdata", mem_wdata, 32'h55);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    check("b2b_st_data", wb_data, 32'hC);
    check("b2b_st_wreg", wb_wreg, 0);
    clr_in();
    tick();

    // reset mid-access, then a stray ack
    load_op(32'h200, 4'd9);
    tick();
    check("mid_req", mem_req, 1);
    rst = 1;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_valid", wb_valid, 0);
    check("mid_rst_data", wb_data, 0);
    check("mid_rst_err", mem_err, 0);
    clr_in();
    tick();
    rst = 0;
    tick();
    mem_ack = 1; mem_rdata = 32'hBAD;
    tick();
    mem_ack = 0;
    check("stray_req", mem_req, 0);
    check("stray_valid", wb_valid, 0);
    check("stray_data", wb_data, 0);
    tick();
    check("stray_valid2", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
